// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared definitions for the pipeline registers, the
//                forwarding unit and the writeback/register-file stage.
//                Holds the datapath width, register-address width, the
//                rd field position and the bubble encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int          XLEN        = 32;
  localparam int          REG_ADDR_W  = 5;
  localparam int          RD_LSB      = 7;
  localparam int          RD_MSB      = 11;
  localparam logic [31:0] BUBBLE_INST = 32'h0;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : Integer register file with one write port and two
//                combinational read ports. x0 is hardwired to zero. With
//                BYPASS=1 a read of the register being written this cycle
//                returns the incoming write data.
//  Ports       : clk, rst (async, active-high)
//                i_we, i_waddr, i_wdata       - write port
//                i_raddr1/2 -> o_rdata1/2     - read ports
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
  import rv_pkg::REG_ADDR_W;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic [XLEN-1:0]       o_rdata1,
  output logic [XLEN-1:0]       o_rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  // Entry 0 is held at zero so the array never contains X; every entry
  // is cleared by reset, so unwritten registers read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_regs[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (i_we && (int'(i_waddr) == i)) begin
          r_regs[i] <= i_wdata;
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] f_read(input logic [REG_ADDR_W-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (a == '0) begin
      v = '0;
    end else if ((BYPASS != 0) && i_we && (a == i_waddr)) begin
      v = i_wdata;
    end else if (int'(a) < NREG) begin
      v = r_regs[a];
    end
    return v;
  endfunction

  always_comb begin
    o_rdata1 = f_read(i_raddr1);
    o_rdata2 = f_read(i_raddr2);
  end

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Writeback stage. Selects load/ALU result from the MEM/WB
//                bundle, qualifies the write enable (x0 writes dropped),
//                commits into the register file and counts retired
//                (non-bubble) instructions.
//  Ports       : clk_i, rst_i (async, active-high)
//                RegWrite_i, MemtoReg_i, ALUresult_i, ReadData_i, Inst_i
//                RS1addr_i/RS2addr_i -> RS1data_o/RS2data_o (ID read ports)
//                WBdata_o, WBaddr_o, WBen_o (exported for EX forwarding)
//                instret_o (retired-instruction count)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREG   = 32,
  parameter int CNT_W  = 64,
  parameter int BYPASS = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          RegWrite_i,
  input  logic                          MemtoReg_i,
  input  logic [XLEN-1:0]               ALUresult_i,
  input  logic [XLEN-1:0]               ReadData_i,
  input  logic [31:0]                   Inst_i,
  input  logic [rv_pkg::REG_ADDR_W-1:0] RS1addr_i,
  input  logic [rv_pkg::REG_ADDR_W-1:0] RS2addr_i,
  output logic [XLEN-1:0]               RS1data_o,
  output logic [XLEN-1:0]               RS2data_o,
  output logic [XLEN-1:0]               WBdata_o,
  output logic [rv_pkg::REG_ADDR_W-1:0] WBaddr_o,
  output logic                          WBen_o,
  output logic [CNT_W-1:0]              instret_o
);

  import rv_pkg::*;

  logic [XLEN-1:0]       w_wbdata;
  logic [REG_ADDR_W-1:0] w_wbaddr;
  logic                  w_wben;
  logic [CNT_W-1:0]      r_instret;

  assign w_wbdata = MemtoReg_i ? ReadData_i : ALUresult_i;
  assign w_wbaddr = Inst_i[RD_MSB:RD_LSB];
  assign w_wben   = RegWrite_i && (w_wbaddr != '0);

  regfile_2r1w #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_we     (w_wben),
    .i_waddr  (w_wbaddr),
    .i_wdata  (w_wbdata),
    .i_raddr1 (RS1addr_i),
    .i_raddr2 (RS2addr_i),
    .o_rdata1 (RS1data_o),
    .o_rdata2 (RS2data_o)
  );

  // Every non-bubble instruction retires here, whether or not it writes rd.
  // The counter wraps freely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instret <= '0;
    end else if (Inst_i != BUBBLE_INST) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign WBdata_o  = w_wbdata;
  assign WBaddr_o  = w_wbaddr;
  assign WBen_o    = w_wben;
  assign instret_o = r_instret;

endmodule : wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback end of the MEM/WB pipeline register: consumes the registered writeback bundle and commits the result to the integer register file.
- Provides the two ID-stage read ports, with same-cycle write-to-read bypass, so no separate WB-to-ID forwarding path is needed.
- Keeps a retired-instruction counter for lab performance measurements.

Parameters:
- XLEN, 32, data width of the register file and writeback path.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_W, 64, width of the retired-instruction counter.
- BYPASS, 1, 1 = a read of the register being written this cycle returns the new data; 0 = it returns the stored value.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-high.
- RegWrite_i  input  1  writeback enable, from MEM/WB.
- MemtoReg_i  input  1  1 = write ReadData_i, 0 = write ALUresult_i.
- ALUresult_i  input  XLEN  ALU result, from MEM/WB.
- ReadData_i  input  XLEN  data-memory load result, from MEM/WB.
- Inst_i  input  32  instruction in WB; all-zero marks a bubble.
- RS1addr_i  input  5  read port 1 address (ID stage).
- RS2addr_i  input  5  read port 2 address (ID stage).
- RS1data_o  output  XLEN  read port 1 data.
- RS2data_o  output  XLEN  read port 2 data.
- WBdata_o  output  XLEN  selected writeback data, exported for EX forwarding.
- WBaddr_o  output  5  destination register, Inst_i[11:7].
- WBen_o  output  1  effective write enable.
- instret_o  output  CNT_W  retired-instruction count.

Behaviour:
- Writeback data and address (combinational):
  - WBdata_o = MemtoReg_i ? ReadData_i : ALUresult_i.
  - WBaddr_o = Inst_i[11:7].
  - WBen_o = RegWrite_i & (WBaddr_o != 0).
- Register write:
  - On each rising edge with WBen_o=1: regs[WBaddr_o] <= WBdata_o.
  - Writes to x0 are dropped; x0 always reads 0.
- Read ports (combinational, zero latency), for each port p:
  - addr_p == 0 -> 0.
  - else BYPASS=1 & WBen_o & addr_p == WBaddr_o -> WBdata_o.
  - else -> regs[addr_p].
  - Both ports may read the same address; both return identical data.
- Write latency: data written at edge N is visible from storage after edge N. With BYPASS it is also visible during the cycle before edge N.
- Retire counter:
  - On each rising edge where Inst_i != 32'h0, instret_o <= instret_o + 1.
  - Bubbles (all-zero Inst_i) are not counted. RegWrite_i is irrelevant to counting, so stores and branches count.
  - Counter wraps modulo 2^CNT_W with no saturation and no flag.
- Reset:
  - rst_i=1 asynchronously clears all registers and instret_o to 0, independent of the clock.
  - Outputs reflect the cleared state while rst_i is held.
  - A write presented in the same cycle that reset is asserted is lost.
  - The first write is taken on the first rising edge after rst_i deasserts.
- Reset output values:
  - RS1data_o and RS2data_o = 0, unless the bypass path is active from live inputs (combinational).
  - instret_o = 0.
  - WBdata_o, WBaddr_o and WBen_o are purely combinational and follow their inputs.
- No X propagation: reading any register before its first write returns 0.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN.
  - REG_ADDR_W=5.
  - RD_LSB=7 and RD_MSB=11 field positions.
  - BUBBLE_INST=32'h0.
  - The same package is reused by the IF/ID, ID/EX, EX/MEM and MEM/WB registers and by the forwarding unit.
- One natural sub-module: regfile_2r1w. It holds the storage array, x0 handling, the write port and the two bypassed read ports.
- The top level adds the MemtoReg mux, WBen qualification and the instret counter.

Test Plan:
- Reset, then read x1..x31 on both ports -> all return 0; instret_o = 0.
- Write, then read back:
  - Stimulus: RegWrite=1, MemtoReg=0, ALUresult=32'hDEADBEEF, Inst rd=5, for one edge; then RS1addr=5.
  - Required: RS1data=32'hDEADBEEF.
  - Repeat with MemtoReg=1, ReadData=32'h12345678, rd=6 -> RS2addr=6 reads 32'h12345678.
- Same-cycle bypass: RegWrite=1, rd=7, ALUresult=32'hA5A5A5A5, RS1addr=RS2addr=7 in the same cycle -> both outputs read 32'hA5A5A5A5 before the edge.
- Write to x0: RegWrite=1, rd=0, ALUresult=32'hFFFFFFFF -> WBen_o=0; x0 reads 0 before and after the edge.
- Retire counting: 10 cycles alternating Inst=32'h00500293 and Inst=32'h0 -> instret_o=5.
- Reset mid-operation:
  - Stimulus: after writing x3=32'h1 with instret_o=4, pulse rst_i between clock edges.
  - Required: x3 and instret_o read 0 immediately, without waiting for a clock edge.
  - After release, the next write to x3 takes effect on the first rising edge.
